ray_frame_scheduler: RTL and testbench

Sequences the ray-marcher datapath one frame at a time. It issues screen coordinates to the ray unit under credit-based flow control, so in-flight pixels can never overrun the packer/output buffer. It shadows the AXI-Lite light-position registers at frame boundaries, so a frame never renders with mixed light positions. It sits between the AXI-Lite register file and the ray_unit/packer chain in pixel_generator.

---
 rtl/ray_frame_scheduler_pkg.sv | 20 ++
 rtl/ray_frame_scheduler_credit_counter.sv | 42 ++++
 rtl/ray_frame_scheduler.sv | 152 +++++++++++++++
 tb/tb_ray_frame_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_frame_scheduler_pkg.sv
// Shared definitions for the ray-marcher frame scheduler: default screen geometry,
// scheduler state encoding and the Q8.24 light-position type.
package ray_frame_scheduler_pkg;

    localparam int DEF_SCREEN_WIDTH  = 640;
    localparam int DEF_SCREEN_HEIGHT = 480;
    localparam int DEF_CREDITS       = 16;
    localparam int DEF_X_W           = 10;
    localparam int DEF_Y_W           = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    typedef logic [31:0] q8_24_t;

endpackage

// File: rtl/ray_frame_scheduler_credit_counter.sv
// Up/down in-flight counter with a saturation guard at MAX and a sticky flag that
// records any decrement requested while the counter is already empty.
module credit_counter #(
    parameter int MAX   = 16,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

    logic inc_ok;
    logic dec_ok;

    assign dec_ok = dec && (count != '0);
    assign inc_ok = inc && (count != MAX_CNT);
    assign full   = (count == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            case ({inc_ok, dec_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // An empty-counter retire is dropped; only the flag remembers it.
            if (dec && (count == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Frame sequencer for the ray-marcher: raster-issues pixel coordinates under credit
// flow control and latches the light position once per frame.
module ray_frame_scheduler
    import ray_frame_scheduler_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int CREDITS       = DEF_CREDITS,
    parameter int X_W           = DEF_X_W,
    parameter int Y_W           = DEF_Y_W,
    parameter int CNT_W         = $clog2(CREDITS + 1)
) (
    input  logic             out_stream_aclk,
    input  logic             periph_resetn,
    input  logic             cfg_enable,
    input  logic             cfg_single,
    input  q8_24_t           cfg_light_x,
    input  q8_24_t           cfg_light_y,
    input  q8_24_t           cfg_light_z,
    output q8_24_t           light_x,
    output q8_24_t           light_y,
    output q8_24_t           light_z,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [X_W-1:0]   issue_x,
    output logic [Y_W-1:0]   issue_y,
    output logic             issue_sof,
    output logic             issue_eol,
    input  logic             retire,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] inflight,
    output logic [15:0]      frame_count,
    output logic             retire_err,
    output sched_state_t     state_dbg
);

    if (SCREEN_WIDTH > (1 << X_W)) begin : g_bad_x_w
        $error("SCREEN_WIDTH does not fit in X_W bits");
    end
    if (SCREEN_HEIGHT > (1 << Y_W)) begin : g_bad_y_w
        $error("SCREEN_HEIGHT does not fit in Y_W bits");
    end

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_HEIGHT - 1);

    sched_state_t   state;
    sched_state_t   state_nxt;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           credit_full;
    logic           issue_fire;
    logic           last_x;
    logic           last_y;

    // Issue channel: a coordinate transfers on any cycle with issue_valid && issue_ready;
    // once valid is high it stays high with x/y/sof/eol frozen until that transfer.
    assign issue_fire = issue_valid & issue_ready;
    assign last_x     = (x_q == X_LAST);
    assign last_y     = (y_q == Y_LAST);

    credit_counter #(
        .MAX   (CREDITS),
        .CNT_W (CNT_W)
    ) u_credits (
        .clk       (out_stream_aclk),
        .rst_n     (periph_resetn),
        .inc       (issue_fire),
        .dec       (retire),
        .count     (inflight),
        .full      (credit_full),
        .underflow (retire_err)
    );

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        issue_valid = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_enable || cfg_single) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                issue_valid = !credit_full;
                if (issue_fire && last_x && last_y) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    frame_done = 1'b1;
                    state_nxt  = cfg_enable ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            x_q         <= '0;
            y_q         <= '0;
            light_x     <= '0;
            light_y     <= '0;
            light_z     <= '0;
            frame_count <= '0;
        end else begin
            if (state == LOAD) begin
                light_x <= cfg_light_x;
                light_y <= cfg_light_y;
                light_z <= cfg_light_z;
                x_q     <= '0;
                y_q     <= '0;
            end else if (issue_fire) begin
                if (last_x) begin
                    x_q <= '0;
                    y_q <= last_y ? '0 : y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Markers are qualified by valid so they read 0 whenever nothing is offered.
    assign issue_x   = x_q;
    assign issue_y   = y_q;
    assign issue_sof = issue_valid && (x_q == '0) && (y_q == '0);
    assign issue_eol = issue_valid && last_x;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed bench for ray_frame_scheduler on an 8x4 screen with 4 credits.
module tb_ray_frame_scheduler;
    import ray_frame_scheduler_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 3;
    localparam int OW = 2 + YW + XW;
    localparam int NPIX = W * H;

    logic          out_stream_aclk = 1'b0;
    logic          periph_resetn   = 1'b0;
    logic          cfg_enable      = 1'b0;
    logic          cfg_single      = 1'b0;
    q8_24_t        cfg_light_x     = '0;
    q8_24_t        cfg_light_y     = '0;
    q8_24_t        cfg_light_z     = '0;
    q8_24_t        light_x, light_y, light_z;
    logic          issue_valid;
    logic          issue_ready     = 1'b0;
    logic [XW-1:0] issue_x;
    logic [YW-1:0] issue_y;
    logic          issue_sof, issue_eol;
    logic          retire          = 1'b0;
    logic          busy, frame_done;
    logic [CW-1:0] inflight;
    logic [15:0]   frame_count;
    logic          retire_err;
    sched_state_t  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0, hs_total = 0, done_seen = 0, retired_total = 0, retired_at_done = 0;
    int max_inflight = 0, coord_changes = 0, exp_frames = 0;
    bit auto_retire = 1'b0, timed_out = 1'b0, prev_stall = 1'b0;
    logic [XW-1:0] prev_x = '0;
    logic [YW-1:0] prev_y = '0;
    int            ret_q[$];
    logic [OW-1:0] obs_q[$];
    logic [OW-1:0] exp_q[$];

    ray_frame_scheduler #(
        .SCREEN_WIDTH (W), .SCREEN_HEIGHT (H), .CREDITS (4),
        .X_W (XW), .Y_W (YW), .CNT_W (CW)
    ) dut (
        .out_stream_aclk (out_stream_aclk), .periph_resetn (periph_resetn),
        .cfg_enable (cfg_enable), .cfg_single (cfg_single),
        .cfg_light_x (cfg_light_x), .cfg_light_y (cfg_light_y), .cfg_light_z (cfg_light_z),
        .light_x (light_x), .light_y (light_y), .light_z (light_z),
        .issue_valid (issue_valid), .issue_ready (issue_ready),
        .issue_x (issue_x), .issue_y (issue_y),
        .issue_sof (issue_sof), .issue_eol (issue_eol),
        .retire (retire), .busy (busy), .frame_done (frame_done),
        .inflight (inflight), .frame_count (frame_count),
        .retire_err (retire_err), .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 out_stream_aclk = ~out_stream_aclk;

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the edge; outputs are observed 1 unit later.
    task automatic cycle(input bit rdy);
        @(posedge out_stream_aclk);
        #1;
        cyc++;
        issue_ready = rdy;
        retire      = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
            retire = 1'b1;
            void'(ret_q.pop_front());
            retired_total++;
        end
        #1;
        if (prev_stall && (!issue_valid || issue_x != prev_x || issue_y != prev_y)) coord_changes++;
        prev_stall = issue_valid && !issue_ready;
        prev_x     = issue_x;
        prev_y     = issue_y;
        if (issue_valid && issue_ready) begin
            hs_total++;
            obs_q.push_back({issue_sof, issue_eol, issue_y, issue_x});
            if (auto_retire) ret_q.push_back(cyc + 5);
        end
        if (frame_done) begin
            done_seen++;
            retired_at_done = retired_total;
        end
        if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
    endtask

    task automatic pulse_single();
        cfg_single = 1'b1;
        cycle(1'b1);
        cfg_single = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit rnd);
        int start;
        start     = done_seen;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (done_seen != start) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic new_frame_sb();
        logic [OW-1:0] v;
        obs_q.delete();
        exp_q.delete();
        hs_total      = 0;
        retired_total = 0;
        max_inflight  = 0;
        coord_changes = 0;
        prev_stall    = 1'b0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                v = {(x == 0 && y == 0), (x == W - 1), YW'(y), XW'(x)};
                exp_q.push_back(v);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge out_stream_aclk);
        #1 periph_resetn = 1'b1;
        cycle(1'b0);
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0h exp=0", issue_valid); end
        n_cmp++; if ({issue_x, issue_y, issue_sof, issue_eol} !== '0) begin n_bad++; $display("FAIL rst_coord got=%0h/%0h exp=0", issue_x, issue_y); end
        n_cmp++; if ({busy, frame_done, retire_err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b exp=000", {busy, frame_done, retire_err}); end
        n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
        n_cmp++; if ({light_x, light_y, light_z} !== 96'd0) begin n_bad++; $display("FAIL rst_light got=%0h exp=0", {light_x, light_y, light_z}); end
        n_cmp++; if (state_dbg !== IDLE) begin n_bad++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, IDLE); end
    endtask

    task automatic test_single_frame();
        new_frame_sb();
        auto_retire = 1'b1;
        pulse_single();
        n_cmp++; if (issue_valid !== 1'b0 || state_dbg !== LOAD) begin n_bad++; $display("FAIL sf_lat1 got=v%0d s%0d exp=v0 s%0d", issue_valid, state_dbg, LOAD); end
        cycle(1'b1);
        n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL sf_lat2 got=%0d exp=1", issue_valid); end
        run_to_done(400, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL sf_timeout got=%0d exp=0", timed_out); end
        n_cmp++; if (retired_at_done !== NPIX) begin n_bad++; $display("FAIL sf_retired_at_done got=%0d exp=%0d", retired_at_done, NPIX); end
        repeat (3) cycle(1'b1);
        exp_frames++;
        n_cmp++; if (hs_total !== NPIX) begin n_bad++; $display("FAIL sf_handshakes got=%0d exp=%0d", hs_total, NPIX); end
        n_cmp++; if (done_seen !== 1) begin n_bad++; $display("FAIL sf_done_pulses got=%0d exp=1", done_seen); end
        n_cmp++; if (frame_count !== 16'(exp_frames)) begin n_bad++; $display("FAIL sf_frame_count got=%0d exp=%0d", frame_count, exp_frames); end
        n_cmp++; if (state_dbg !== IDLE || busy !== 1'b0) begin n_bad++; $display("FAIL sf_final_state got=%0d exp=%0d", state_dbg, IDLE); end
        n_cmp++; if (max_inflight !== 4) begin n_bad++; $display("FAIL sf_max_inflight got=%0d exp=4", max_inflight); end
        for (int i = 0; i < NPIX && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sf_pixel%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_credit_stall();
        new_frame_sb();
        auto_retire = 1'b0;
        pulse_single();
        repeat (8) cycle(1'b1);
        n_cmp++; if (hs_total !== 4) begin n_bad++; $display("FAIL cs_hs_before got=%0d exp=4", hs_total); end
        n_cmp++; if (issue_valid !== 1'b0 || inflight !== 3'd4) begin n_bad++; $display("FAIL cs_stalled got=v%0d i%0d exp=v0 i4", issue_valid, inflight); end
        ret_q.push_back(cyc + 1);
        repeat (6) cycle(1'b1);
        n_cmp++; if (hs_total !== 5) begin n_bad++; $display("FAIL cs_hs_after_one got=%0d exp=5", hs_total); end
        n_cmp++; if (issue_valid !== 1'b0 || inflight !== 3'd4) begin n_bad++; $display("FAIL cs_restalled got=v%0d i%0d exp=v0 i4", issue_valid, inflight); end
        auto_retire = 1'b1;
        for (int k = 1; k <= 4; k++) ret_q.push_back(cyc + k);
        run_to_done(400, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL cs_timeout got=%0d exp=0", timed_out); end
        repeat (3) cycle(1'b1);
        exp_frames++;
        n_cmp++; if (obs_q.size() !== NPIX) begin n_bad++; $display("FAIL cs_pixels got=%0d exp=%0d", obs_q.size(), NPIX); end
        for (int i = 0; i < NPIX && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL cs_pixel%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        new_frame_sb();
        auto_retire = 1'b1;
        pulse_single();
        run_to_done(1000, 1'b1);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got=%0d exp=0", timed_out); end
        repeat (3) cycle(1'b1);
        exp_frames++;
        n_cmp++; if (coord_changes !== 0) begin n_bad++; $display("FAIL bp_stall_stability got=%0d exp=0", coord_changes); end
        n_cmp++; if (obs_q.size() !== NPIX) begin n_bad++; $display("FAIL bp_pixels got=%0d exp=%0d", obs_q.size(), NPIX); end
        for (int i = 0; i < NPIX && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_pixel%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_light_shadow();
        new_frame_sb();
        auto_retire = 1'b1;
        cfg_light_x = 32'h0093EA1C;
        cfg_light_y = 32'h00400000;
        pulse_single();
        cycle(1'b1);
        for (int i = 0; i < 100 && hs_total < 10; i++) cycle(1'b1);
        n_cmp++; if (light_x !== 32'h0093EA1C) begin n_bad++; $display("FAIL ls_loaded got=%0h exp=0093ea1c", light_x); end
        cfg_light_x = 32'h01000000;
        run_to_done(400, 1'b0);
        n_cmp++; if (light_x !== 32'h0093EA1C) begin n_bad++; $display("FAIL ls_held got=%0h exp=0093ea1c", light_x); end
        repeat (3) cycle(1'b1);
        pulse_single();
        cycle(1'b1);
        n_cmp++; if (light_x !== 32'h01000000) begin n_bad++; $display("FAIL ls_reloaded got=%0h exp=01000000", light_x); end
        n_cmp++; if (light_y !== 32'h00400000) begin n_bad++; $display("FAIL ls_light_y got=%0h exp=00400000", light_y); end
        run_to_done(400, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL ls_timeout got=%0d exp=0", timed_out); end
        repeat (3) cycle(1'b1);
        exp_frames += 2;
    endtask

    task automatic test_continuous();
        int target;
        new_frame_sb();
        auto_retire = 1'b1;
        cfg_enable  = 1'b1;
        for (int f = 0; f < 2; f++) begin
            run_to_done(400, 1'b0);
            n_cmp++; if (timed_out !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL cm_done%0d got=t%0d b%0d exp=t0 b1", f, timed_out, busy); end
            cycle(1'b1);
            n_cmp++; if (issue_valid !== 1'b0 || state_dbg !== LOAD) begin n_bad++; $display("FAIL cm_gap1_%0d got=v%0d s%0d exp=v0 s%0d", f, issue_valid, state_dbg, LOAD); end
            cycle(1'b1);
            n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL cm_gap2_%0d got=%0d exp=1", f, issue_valid); end
        end
        target = hs_total + 10;
        for (int i = 0; i < 100 && hs_total < target; i++) cycle(1'b1);
        cfg_enable = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cm_busy_mid got=%0d exp=1", busy); end
        run_to_done(400, 1'b0);
        n_cmp++; if (timed_out !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL cm_last_done got=t%0d b%0d exp=t0 b1", timed_out, busy); end
        cycle(1'b1);
        n_cmp++; if (busy !== 1'b0 || state_dbg !== IDLE) begin n_bad++; $display("FAIL cm_idle got=b%0d s%0d exp=b0 s%0d", busy, state_dbg, IDLE); end
        repeat (4) cycle(1'b1);
        exp_frames += 3;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cm_stays_idle got=%0d exp=0", busy); end
        n_cmp++; if (frame_count !== 16'(exp_frames)) begin n_bad++; $display("FAIL cm_frame_count got=%0d exp=%0d", frame_count, exp_frames); end
    endtask

    task automatic test_underflow_reset();
        auto_retire = 1'b0;
        ret_q.push_back(cyc + 1);
        repeat (2) cycle(1'b1);
        n_cmp++; if (retire_err !== 1'b1) begin n_bad++; $display("FAIL ur_err got=%0d exp=1", retire_err); end
        n_cmp++; if (inflight !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL ur_inflight got=%0d exp=0", inflight); end
        new_frame_sb();
        auto_retire = 1'b1;
        pulse_single();
        for (int i = 0; i < 100 && hs_total < 6; i++) cycle(1'b1);
        n_cmp++; if (busy !== 1'b1 || inflight === 3'd0) begin n_bad++; $display("FAIL ur_mid_run got=b%0d i%0d exp=b1 i>0", busy, inflight); end
        #1 periph_resetn = 1'b0;
        #1;
        n_cmp++; if ({busy, issue_valid, retire_err, frame_done} !== 4'b0000) begin n_bad++; $display("FAIL ur_async_flags got=%b exp=0000", {busy, issue_valid, retire_err, frame_done}); end
        n_cmp++; if (inflight !== 3'd0 || frame_count !== 16'd0) begin n_bad++; $display("FAIL ur_async_counts got=%0d/%0d exp=0/0", inflight, frame_count); end
        n_cmp++; if ({light_x, light_y, light_z} !== 96'd0 || {issue_x, issue_y} !== '0) begin n_bad++; $display("FAIL ur_async_data got=%0h/%0h exp=0", light_x, issue_x); end
        n_cmp++; if (state_dbg !== IDLE) begin n_bad++; $display("FAIL ur_async_state got=%0d exp=%0d", state_dbg, IDLE); end
        ret_q.delete();
        auto_retire = 1'b0;
        @(posedge out_stream_aclk);
        #1 periph_resetn = 1'b1;
        repeat (2) cycle(1'b1);
        n_cmp++; if (busy !== 1'b0 || inflight !== 3'd0) begin n_bad++; $display("FAIL ur_post_reset got=b%0d i%0d exp=b0 i0", busy, inflight); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_credit_stall();
        test_backpressure();
        test_light_shadow();
        test_continuous();
        test_underflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
